spu_sched: RTL

Round-robin scheduler that shares one SPU pipeline (spu1 → spu2 → spu3) between NREQ requesters. It accepts one operation per cycle and drives each operand field in the pipeline cycle where the SPU consumes it: ex2/ex3 at issue, ex4 one cycle later, ex1 two cycles later. It captures the 8-bit normalized result into a result FIFO tagged with the requester ID. Credit accounting guarantees that no SPU result is ever dropped, because the SPU pipeline cannot stall.

---
 rtl/spu_sched_pkg.sv | 29 ++
 rtl/spu_sched_chk.sv | 16 +
 rtl/spu_sched_rr.sv | 42 ++++
 rtl/spu_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/spu_sched_pkg.sv
// spu_sched_pkg: shared widths, pipeline tag and result FIFO entry types
// for the SPU round-robin scheduler.
package spu_sched_pkg;

    localparam int EX1_W    = 8;
    localparam int EX2_W    = 64;
    localparam int EX4_W    = 3;
    localparam int EXD_W    = 8;
    // Requester IDs never exceed 3 bits because NREQ is at most 8.
    localparam int ID_MAX_W = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [EX1_W-1:0]    ex1;
        logic [EX4_W-1:0]    ex4;
    } tag_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [EXD_W-1:0]    data;
    } fifo_entry_t;

    // Number of occupied pipeline stages among the two tracked stages.
    function automatic logic [1:0] tag_count(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/spu_sched_chk.sv
// spu_sched_chk: checks that the result FIFO is never written while full.
module spu_sched_chk #(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = 3
) (
    input logic          ACLK,
    input logic          RST,
    input logic          push,
    input logic [CW-1:0] cnt
);

    a_no_push_when_full: assert property (@(posedge ACLK) disable iff (RST)
        push |-> (32'(cnt) < 32'(FIFO_DEPTH)))
        else $error("result FIFO push while full");

endmodule

// File: rtl/spu_sched_rr.sv
// spu_sched_rr: NREQ-way rotating-priority arbiter. The search starts at
// ptr and wraps; next_ptr is the slot just after the winner.
module spu_sched_rr #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         valid,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic [$clog2(NREQ)-1:0] next_ptr
);

    localparam int PW = $clog2(NREQ);

    logic found_s;

    // Modulo-NREQ wrap of a slot index that is at most 2*NREQ-1.
    function automatic logic [PW-1:0] wrap_idx(input int v);
        int w;
        w = (v >= NREQ) ? (v - NREQ) : v;
        return PW'(w);
    endfunction

    // Scan from ptr and pick the first valid requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        next_ptr  = ptr;
        found_s   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && valid[wrap_idx(int'(ptr) + k)]) begin
                found_s                             = 1'b1;
                grant[wrap_idx(int'(ptr) + k)]      = 1'b1;
                grant_idx                           = wrap_idx(int'(ptr) + k);
                next_ptr                            = wrap_idx(int'(ptr) + k + 1);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/spu_sched.sv
// spu_sched: shares one 3-stage SPU pipeline between NREQ requesters with a
// round-robin grant and credit-based issue into a result FIFO.
// Optional feature macro: SPU_SCHED_FOLD_EN (drives spu_fold from req_fold).
module spu_sched
    import spu_sched_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         ACLK,
    input  logic                         RST,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ-1:0][EX1_W-1:0]   req_ex1,
    input  logic [NREQ-1:0][EX2_W-1:0]   req_ex2,
    input  logic [NREQ-1:0][EX2_W-1:0]   req_ex3,
    input  logic [NREQ-1:0][EX4_W-1:0]   req_ex4,
    input  logic [NREQ-1:0]              req_fold,
    output logic                         spu_exec,
    output logic                         spu_fold,
    output logic [EX2_W-1:0]             spu_ex2,
    output logic [EX2_W-1:0]             spu_ex3,
    output logic [EX4_W-1:0]             spu_ex4,
    output logic [EX1_W-1:0]             spu_ex1,
    input  logic [EXD_W-1:0]             spu_exd,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [$clog2(NREQ)-1:0]      res_id,
    output logic [EXD_W-1:0]             res_data,
    output logic                         busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int FPW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    logic [NREQ-1:0] grant_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [IDW-1:0]  next_ptr_s;
    logic [IDW-1:0]  ptr_r;
    logic [1:0]      inflight_s;
    logic            credit_ok_s;
    logic            issue_s;
    tag_t            tag_a_s;
    tag_t            stg_b_r;
    tag_t            stg_c_r;
    fifo_entry_t     mem_r [FIFO_DEPTH];
    fifo_entry_t     head_s;
    logic [FPW-1:0]  wr_ptr_r;
    logic [FPW-1:0]  rd_ptr_r;
    logic [FCW-1:0]  cnt_r;
    logic            push_s;
    logic            pop_s;
    logic            unused_tag_s;

    spu_sched_rr #(.NREQ(NREQ)) u_rr (
        .valid     (req_valid),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .next_ptr  (next_ptr_s)
    );

    // Issue only when every in-flight op already owns a FIFO slot; a pop in
    // this cycle only frees a slot from the next cycle on.
    always_comb begin
        inflight_s  = tag_count(stg_b_r.valid, stg_c_r.valid);
        credit_ok_s = (32'(cnt_r) + 32'(inflight_s)) < 32'(FIFO_DEPTH);
        if (credit_ok_s && !RST && (req_valid != '0)) begin
            issue_s   = 1'b1;
            req_ready = grant_s;
        end else begin
            issue_s   = 1'b0;
            req_ready = '0;
        end
    end

    // Issue-cycle SPU operands and the tag that follows the op down the pipe.
    always_comb begin
        spu_exec = issue_s;
        spu_ex2  = '0;
        spu_ex3  = '0;
        tag_a_s  = '0;
        if (issue_s) begin
            spu_ex2       = req_ex2[grant_idx_s];
            spu_ex3       = req_ex3[grant_idx_s];
            tag_a_s.valid = 1'b1;
            tag_a_s.id    = ID_MAX_W'(grant_idx_s);
            tag_a_s.ex1   = req_ex1[grant_idx_s];
            tag_a_s.ex4   = req_ex4[grant_idx_s];
        end else begin
            tag_a_s = '0;
        end
    end

`ifdef SPU_SCHED_FOLD_EN
    assign spu_fold = issue_s & req_fold[grant_idx_s];
`else
    logic unused_fold_s;
    assign spu_fold      = 1'b0;
    assign unused_fold_s = ^req_fold;
`endif

    // Advance the tag pipeline and the arbitration pointer.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            stg_b_r <= '0;
            stg_c_r <= '0;
            ptr_r   <= '0;
        end else begin
            stg_b_r <= tag_a_s;
            stg_c_r <= stg_b_r;
            if (issue_s) begin
                ptr_r <= next_ptr_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign spu_ex4 = stg_b_r.valid ? stg_b_r.ex4 : '0;
    assign spu_ex1 = stg_c_r.valid ? stg_c_r.ex1 : '0;

    assign push_s = stg_c_r.valid;
    assign pop_s  = (cnt_r != '0) && res_ready;

    // Result storage; capture spu_exd for the op leaving stage C.
    always_ff @(posedge ACLK) begin
        if (push_s && !RST) begin
            mem_r[wr_ptr_r] <= '{id: stg_c_r.id, data: spu_exd};
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge ACLK) begin
        if (RST) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= (wr_ptr_r == FPW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + FPW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == FPW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + FPW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + FCW'(1);
                2'b01:   cnt_r <= cnt_r - FCW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign head_s       = mem_r[rd_ptr_r];
    assign res_valid    = (cnt_r != '0);
    assign res_id       = res_valid ? head_s.id[IDW-1:0] : '0;
    assign res_data     = res_valid ? head_s.data : '0;
    assign busy         = (inflight_s != 2'd0) || res_valid;
    assign unused_tag_s = ^{stg_c_r.ex4, head_s.id};

    spu_sched_chk #(.FIFO_DEPTH(FIFO_DEPTH), .CW(FCW)) u_chk (
        .ACLK (ACLK),
        .RST  (RST),
        .push (push_s),
        .cnt  (cnt_r)
    );

endmodule
